// File: rtl/multi_project_pkg.sv
// Shared definitions for the project switch sequencer: register map, FSM states
// and the caravel pad count.
package multi_project_pkg;

  localparam int MPRJ_IO_PADS = 38;

  // Word index within the 16-byte register window (address bits [3:2]).
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_OEB_LO = 2'd1;
  localparam logic [1:0] REG_OEB_HI = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    SWITCH,
    HOLD_RST,
    RELEASE
  } pss_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pss_wb_regs.sv
// Wishbone slave for the switch sequencer: window decode, single-cycle ack,
// CTRL target/err, staged pad output enables and the completed-switch counter.
module pss_wb_regs
  import multi_project_pkg::*;
#(
  parameter int          NUM_PROJECTS = 6,
  parameter int          IO_PADS      = MPRJ_IO_PADS,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0600
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               busy_i,
  input  logic [7:0]         active_i,
  input  logic               count_inc_i,
  output logic               start_o,
  output logic [7:0]         target_o,
  output logic [IO_PADS-1:0] oeb_o
);

  localparam int HI_W = IO_PADS - 32;

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [7:0]         target_q, target_d;
  logic               err_q, err_d;
  logic [IO_PADS-1:0] oeb_q, oeb_d;
  logic [15:0]        count_q, count_d;
  logic [31:0]        rdata;
  logic [1:0]         reg_idx;
  logic               accept, ctrl_wr, oeb_wr, bad_target;

  assign reg_idx    = wbs_adr_i[3:2];
  // A new cycle is only accepted once the previous ack has dropped.
  assign accept     = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign ctrl_wr    = accept & wbs_we_i & (reg_idx == REG_CTRL) & wbs_sel_i[0];
  assign oeb_wr     = accept & wbs_we_i & (wbs_sel_i == 4'hF);
  assign bad_target = wbs_dat_i[7:0] >= 8'(NUM_PROJECTS);
  assign start_o    = ctrl_wr & ~busy_i & ~bad_target;

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL:   rdata = {14'd0, err_q, busy_i, target_q, active_i};
      REG_OEB_LO: rdata = oeb_q[31:0];
      REG_OEB_HI: rdata[HI_W-1:0] = oeb_q[IO_PADS-1:32];
      REG_COUNT:  rdata = {16'd0, count_q};
    endcase
  end

  always_comb begin
    ack_d    = accept;
    dat_d    = (accept & ~wbs_we_i) ? rdata : '0;
    target_d = start_o ? wbs_dat_i[7:0] : target_q;
    err_d    = ctrl_wr ? ~start_o : err_q;
    oeb_d    = oeb_q;
    if (oeb_wr && reg_idx == REG_OEB_LO) oeb_d[31:0] = wbs_dat_i;
    if (oeb_wr && reg_idx == REG_OEB_HI) oeb_d[IO_PADS-1:32] = wbs_dat_i[HI_W-1:0];
    count_d  = count_inc_i ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
      oeb_q    <= '1;
      count_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      target_q <= target_d;
      err_q    <= err_d;
      oeb_q    <= oeb_d;
      count_q  <= count_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign target_o  = target_q;
  assign oeb_o     = oeb_q;

endmodule

// File: rtl/project_switch_sequencer.sv
// Hands the shared IO pads from one user project to another: isolate pads,
// change mux select, hold the new project in reset, then apply its staged oeb.
//
//  state    | meaning
//  IDLE     | active project running, staged oeb on the pads
//  ISOLATE  | pads input-only, all projects in reset, guard timer running
//  SWITCH   | mux select takes the new target (one cycle)
//  HOLD_RST | new project held in reset, reset timer running
//  RELEASE  | last cycle of the sequence; completed switch counted
module project_switch_sequencer
  import multi_project_pkg::*;
#(
  parameter int          NUM_PROJECTS = 6,
  parameter int          IO_PADS      = MPRJ_IO_PADS,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0600,
  parameter int          GUARD_CYCLES = 16,
  parameter int          RESET_CYCLES = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [7:0]              active_project_o,
  output logic [NUM_PROJECTS-1:0] project_reset_o,
  output logic [IO_PADS-1:0]      io_oeb_o,
  output logic                    busy_o
);

  localparam int CW = $clog2(max_int(GUARD_CYCLES, RESET_CYCLES) + 1);

  pss_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         active_q, active_d;
  logic               seq_q, seq_d;
  logic               start, count_inc;
  logic [7:0]         target;
  logic [IO_PADS-1:0] staged_oeb;

  pss_wb_regs #(
    .NUM_PROJECTS(NUM_PROJECTS),
    .IO_PADS     (IO_PADS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .busy_i     (busy_o),
    .active_i   (active_q),
    .count_inc_i(count_inc),
    .start_o    (start),
    .target_o   (target),
    .oeb_o      (staged_oeb)
  );

  // The post-reset bring-up also passes through RELEASE but is not a requested switch.
  assign count_inc = (state_q == RELEASE) & seq_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    seq_d    = seq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISOLATE;
          cnt_d   = CW'(GUARD_CYCLES);
          seq_d   = 1'b1;
        end
      end
      ISOLATE: begin
        if (cnt_q == CW'(1)) state_d = SWITCH;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      SWITCH: begin
        active_d = target;
        cnt_d    = CW'(RESET_CYCLES);
        state_d  = HOLD_RST;
      end
      HOLD_RST: begin
        if (cnt_q == CW'(1)) state_d = RELEASE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      RELEASE: begin
        seq_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = HOLD_RST;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= HOLD_RST;
      cnt_q    <= CW'(RESET_CYCLES);
      active_q <= '0;
      seq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      seq_q    <= seq_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign active_project_o = active_q;
  assign io_oeb_o         = busy_o ? '1 : staged_oeb;
  assign project_reset_o  = busy_o ? '1 : ~(NUM_PROJECTS'(1) << active_q);

endmodule

// File: tb/tb_project_switch_sequencer.sv
// Directed bench: wishbone responses checked through an expected-data queue,
// pad/reset/select timing checked at hand-computed edge offsets from each ack.
module tb_project_switch_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0600;
  localparam logic [31:0] A_CTRL = BASE + 32'h0, A_OLO = BASE + 32'h4;
  localparam logic [31:0] A_OHI = BASE + 32'h8, A_CNT = BASE + 32'hC;
  localparam logic [37:0] ALL1 = '1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  active;
  logic [5:0]  prst;
  logic [37:0] oeb;
  logic        busy;

  int          total = 0, bad = 0, edge_n = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  project_switch_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .active_project_o(active),
    .project_reset_o(prst), .io_oeb_o(oeb), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: dat_o=%h with no transaction outstanding", rdat);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rdat !== mon_exp) begin
          bad++;
          $display("FAIL wb_data: got %h expected %h", rdat, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic goto(input int k);
    while (edge_n < k) @(negedge clk);
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e, output int ack_edge);
    exp_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    ack_edge = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        ack_edge = edge_n;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    total++;
    if (ack_edge < 0) begin
      bad++;
      $display("FAIL ack_timeout: adr=%h got no ack expected ack within 8 cycles", a);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic no_ack_write(input logic [31:0] a);
    logic seen = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = 32'd1; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("out_of_window_ack", seen, 0);
  endtask

  int a, r0, dummy;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_active", active, 0);
    chk("rst_prst", prst, 6'h3F);
    chk("rst_oeb", oeb, ALL1);
    chk("rst_busy", busy, 1);
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    rst = 1'b0;
    r0 = edge_n;
    goto(r0 + 32); chk("bringup_busy_still", busy, 1);
    goto(r0 + 33);
    chk("bringup_busy", busy, 0);
    chk("bringup_active", active, 0);
    chk("bringup_prst", prst, 6'b111110);
    chk("bringup_oeb", oeb, ALL1);
    xfer(0, A_CNT, 0, 4'hF, 32'd0, dummy);
    xfer(0, A_CTRL, 0, 4'hF, 32'h0000_0000, dummy);

    xfer(1, A_OLO, 32'h0000_FF00, 4'hF, 0, dummy);
    @(negedge clk);
    chk("oeb_idle_write", oeb, {6'h3F, 32'h0000_FF00});
    chk("oeb_idle_prst", prst, 6'b111110);
    xfer(1, A_OHI, 32'h0, 4'h3, 0, dummy);
    xfer(0, A_OHI, 0, 4'hF, 32'h0000_003F, dummy);

    xfer(1, A_CTRL, 32'd3, 4'hF, 0, a);
    @(negedge clk);
    chk("sw3_oeb_isolated", oeb, ALL1);
    chk("sw3_prst_all", prst, 6'h3F);
    chk("sw3_busy", busy, 1);
    goto(a + 16); chk("sw3_sel_before", active, 0);
    goto(a + 17); chk("sw3_sel", active, 3);
    goto(a + 49); chk("sw3_prst_held", prst, 6'h3F);
    goto(a + 50);
    chk("sw3_prst_run", prst, 6'b110111);
    chk("sw3_oeb_applied", oeb, {6'h3F, 32'h0000_FF00});
    chk("sw3_busy_done", busy, 0);
    xfer(0, A_CNT, 0, 4'hF, 32'd1, dummy);
    xfer(0, A_CTRL, 0, 4'hF, 32'h0000_0303, dummy);

    xfer(1, A_CTRL, 32'd9, 4'hF, 0, a);
    repeat (3) @(negedge clk);
    chk("bad_target_busy", busy, 0);
    chk("bad_target_active", active, 3);
    xfer(0, A_CTRL, 0, 4'hF, 32'h0002_0303, dummy);
    no_ack_write(BASE + 32'h10);

    xfer(1, A_CTRL, 32'd5, 4'hF, 0, a);
    xfer(1, A_CTRL, 32'd2, 4'hF, 0, dummy);
    xfer(0, A_CTRL, 0, 4'hF, 32'h0003_0503, dummy);
    goto(a + 17); chk("sw5_sel", active, 5);
    goto(a + 50);
    chk("sw5_prst_run", prst, 6'b011111);
    chk("sw5_busy_done", busy, 0);
    xfer(0, A_CTRL, 0, 4'hF, 32'h0002_0505, dummy);
    xfer(0, A_CNT, 0, 4'hF, 32'd2, dummy);

    xfer(1, A_CTRL, 32'd5, 4'hF, 0, a);
    xfer(1, A_OLO, 32'h1234_5678, 4'hF, 0, dummy);
    @(negedge clk);
    chk("busy_oeb_write_held", oeb, ALL1);
    goto(a + 50);
    chk("same_target_oeb", oeb, {6'h3F, 32'h1234_5678});
    chk("same_target_prst", prst, 6'b011111);
    chk("same_target_busy", busy, 0);
    xfer(0, A_CNT, 0, 4'hF, 32'd3, dummy);
    xfer(0, A_CTRL, 0, 4'hF, 32'h0000_0505, dummy);

    xfer(1, A_CTRL, 32'd2, 4'hF, 0, a);
    goto(a + 30);
    chk("hold_active", active, 2);
    chk("hold_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_active", active, 0);
    chk("midrst_prst", prst, 6'h3F);
    chk("midrst_oeb", oeb, ALL1);
    chk("midrst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    r0 = edge_n;
    goto(r0 + 33);
    chk("rerun_active", active, 0);
    chk("rerun_prst", prst, 6'b111110);
    chk("rerun_busy", busy, 0);
    xfer(0, A_CNT, 0, 4'hF, 32'd0, dummy);
    xfer(0, A_OLO, 0, 4'hF, 32'hFFFF_FFFF, dummy);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
